spi_host_ctrl: RTL

- Host-side SPI master that drives the serial end of the RAM-backed SPI slave subsystem.
- Turns a parallel command request (cmd, payload) into an SS_n/MOSI frame and, for read-data commands, captures the returned byte from MISO.
- Shares the system clock with the slave; no separate SCLK. Both ends sample on the posedge of clk.
- Used as the bus-facing driver in system benches and as the host port in integrated tops.

---
 rtl/spi_pkg.sv | 24 ++
 rtl/spi_host_ctrl.sv | 129 ++++++++++++
 2 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions for the host controller and the RAM-backed slave:
// command encodings, frame sequencing states and the frame-width helper.
package spi_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WAKE,
        SEND,
        GAP,
        RECV,
        END
    } spi_state_e;

    // Serial word is {rw_select, cmd[1:0], payload}
    function automatic int frame_width(input int addr_size);
        return addr_size + 3;
    endfunction

endpackage

// File: rtl/spi_host_ctrl.sv
// Host-side SPI master sharing clk with the slave: serialises {cmd, payload}
// onto SS_n/MOSI and, for read-data commands, captures one byte from MISO.
//
// state | meaning
// IDLE  | SS_n high, waiting for start
// WAKE  | SS_n low, one quiet cycle before the first bit
// SEND  | shifting the frame-wide serial word out MSB first
// GAP   | RD_GAP turnaround cycles on read-data frames, MISO ignored
// RECV  | ADDR_SIZE cycles sampling MISO MSB first
// END   | SS_n high, done pulse (and rdata_valid on read-data)
module spi_host_ctrl
    import spi_pkg::*;
#(
    parameter int ADDR_SIZE = 8,
    parameter int RD_GAP    = 2    // must be >= 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           cmd,
    input  logic [ADDR_SIZE-1:0] payload,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_SIZE-1:0] rdata,
    output logic                 rdata_valid,
    output logic                 SS_n,
    output logic                 MOSI,
    input  logic                 MISO
);

    localparam int F   = frame_width(ADDR_SIZE);
    localparam int SCW = $clog2(F + 1);
    localparam int WCW = $clog2(RD_GAP + ADDR_SIZE + 1);

    spi_state_e           state;
    logic [F-1:0]         tx_sr;
    // One bit short: the last MISO bit goes straight into rdata on the final edge
    logic [ADDR_SIZE-2:0] rx_sr;
    logic [SCW-1:0]       send_cnt;
    logic [WCW-1:0]       wait_cnt;
    logic                 rd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            SS_n        <= 1'b1;
            MOSI        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            rdata_valid <= 1'b0;
            rdata       <= '0;
            rd_q        <= 1'b0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            send_cnt    <= '0;
            wait_cnt    <= '0;
        end else begin
            done        <= 1'b0;
            rdata_valid <= 1'b0;
            case (state)
                IDLE: begin
                    SS_n <= 1'b1;
                    busy <= 1'b0;
                    MOSI <= 1'b0;
                    if (start) begin
                        tx_sr <= {cmd[1], cmd, payload};
                        rd_q  <= (cmd == CMD_RD_DATA);
                        rx_sr <= '0;
                        SS_n  <= 1'b0;
                        busy  <= 1'b1;
                        state <= WAKE;
                    end
                end
                WAKE: begin
                    MOSI     <= tx_sr[F-1];
                    tx_sr    <= {tx_sr[F-2:0], 1'b0};
                    send_cnt <= SCW'(F - 1);
                    state    <= SEND;
                end
                SEND: begin
                    if (send_cnt == '0) begin
                        MOSI <= 1'b0;
                        if (rd_q) begin
                            wait_cnt <= WCW'(RD_GAP - 1);
                            state    <= GAP;
                        end else begin
                            SS_n  <= 1'b1;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= END;
                        end
                    end else begin
                        MOSI     <= tx_sr[F-1];
                        tx_sr    <= {tx_sr[F-2:0], 1'b0};
                        send_cnt <= send_cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (wait_cnt == '0) begin
                        wait_cnt <= WCW'(ADDR_SIZE - 1);
                        state    <= RECV;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                RECV: begin
                    rx_sr <= {rx_sr[ADDR_SIZE-3:0], MISO};
                    if (wait_cnt == '0) begin
                        rdata       <= {rx_sr, MISO};
                        rdata_valid <= 1'b1;
                        done        <= 1'b1;
                        SS_n        <= 1'b1;
                        busy        <= 1'b0;
                        state       <= END;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                END: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
